// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with a one-entry write buffer, load forwarding and request timeout
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [1:0] {IDLE, WDRAIN, RD, RDONE} state_e;
  state_e          state_q, state_d;
  logic            wb_valid_q, wb_valid_d;
  logic [31:0]     wb_addr_q, wb_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ld, hit, ack, tmo;
  // a simultaneous load+store is treated as a store only
  assign ld        = rd_i & ~wr_i;
  assign hit       = ld & wb_valid_q & (addr_i[31:2] == wb_addr_q[31:2]);
  assign mem_req_o = (state_q == WDRAIN) | (state_q == RD);
  assign ack       = mem_req_o & mem_ack_i;
  assign tmo       = mem_req_o & ~mem_ack_i & (cnt_q == CW'(TIMEOUT - 1));
  assign err_o     = err_q;
  // memory-side and pipeline-side outputs derived from state and buffer
  always_comb begin
    mem_we_o    = state_q == WDRAIN;
    mem_addr_o  = (state_q == WDRAIN) ? wb_addr_q : (state_q == RD) ? addr_i : '0;
    mem_wdata_o = (state_q == WDRAIN) ? wb_data_q : '0;
    stall_o     = ~rst_i & ((wr_i & wb_valid_q) | (ld & ~hit & (state_q != RDONE)));
    rvalid_o    = ~rst_i & ld & (hit | (state_q == RDONE));
    rdata_o     = (hit && state_q != RDONE) ? wb_data_q : rdata_q;
  end
  // next-state: drain buffer first, then capture stores or issue load misses
  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    rdata_d    = rdata_q;
    cnt_d      = '0;
    err_d      = err_q | (rd_i & wr_i) | tmo;
    unique case (state_q)
      IDLE: begin
        if (wb_valid_q) begin
          state_d = WDRAIN;
        end else if (wr_i) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = addr_i;
          wb_data_d  = wdata_i;
        end else if (ld) begin
          state_d = RD;
        end
      end
      WDRAIN: begin
        if (ack | tmo) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD: begin
        if (ack | tmo) begin
          rdata_d = ack ? mem_rdata_i : '0;
          state_d = RDONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RDONE: state_d = IDLE;
    endcase
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a behavioural model
module tb_dmem_ctrl;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        rst_i, rd_i, wr_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        stall_o, rvalid_o, mem_req_o, mem_we_o, err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a buffered store waiting to drain, at most one outstanding
  // memory operation (1 = write, 2 = read) and a finished-load result to present.
  logic        m_wbv, m_done, m_err, e_ld, e_hit;
  logic [31:0] m_wba, m_wbd, m_res;
  int          m_busy, m_wait;

  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      chkb("rst_stall", stall_o, 1'b0);
      chkb("rst_rvalid", rvalid_o, 1'b0);
      chkb("rst_req", mem_req_o, 1'b0);
      chkb("rst_we", mem_we_o, 1'b0);
      chkb("rst_err", err_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_maddr", mem_addr_o, 32'h0);
      chk("rst_mwdata", mem_wdata_o, 32'h0);
      m_wbv = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 0; m_wait = 0;
      m_wba = 32'h0; m_wbd = 32'h0; m_res = 32'h0;
    end else begin
      e_ld  = rd_i & ~wr_i;
      e_hit = e_ld & m_wbv & (addr_i[31:2] == m_wba[31:2]);
      chkb("m_req", mem_req_o, m_busy != 0);
      chkb("m_we", mem_we_o, m_busy == 1);
      chk("m_maddr", mem_addr_o, (m_busy == 1) ? m_wba : (m_busy == 2) ? addr_i : 32'h0);
      chk("m_mwdata", mem_wdata_o, (m_busy == 1) ? m_wbd : 32'h0);
      chkb("m_stall", stall_o, (wr_i & m_wbv) | (e_ld & ~e_hit & ~m_done));
      chkb("m_rvalid", rvalid_o, e_ld & (m_done | e_hit));
      if (e_ld & (m_done | e_hit)) chk("m_rdata", rdata_o, m_done ? m_res : m_wbd);
      chkb("m_err", err_o, m_err);
      m_err = m_err | (rd_i & wr_i);
      if (m_done) m_done = 1'b0;
      else if (m_busy != 0) begin
        if (mem_ack_i || m_wait == T - 1) begin
          if (m_busy == 1) m_wbv = 1'b0;
          else begin
            m_res  = mem_ack_i ? mem_rdata_i : 32'h0;
            m_done = 1'b1;
          end
          if (!mem_ack_i) m_err = 1'b1;
          m_busy = 0;
        end else m_wait++;
      end else if (m_wbv) begin
        m_busy = 1; m_wait = 0;
      end else if (wr_i) begin
        m_wbv = 1'b1; m_wba = addr_i; m_wbd = wdata_i;
      end else if (e_ld) begin
        m_busy = 2; m_wait = 0;
      end
    end
  end

  task automatic drain_ack();
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) begin
        mem_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b0;
        return;
      end
      cyc();
    end
    chkb("drain_wait_bound", 1'b0, 1'b1);
  endtask

  logic q_we[$];
  logic done, st_prev;
  int   lat_cnt, lat_tgt, r;

  initial begin
    rst_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; addr_i = 32'h44; wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chkb("d_rst_stall", stall_o, 1'b0);
    chkb("d_rst_req", mem_req_o, 1'b0);
    cyc();
    rst_i = 1'b0; rd_i = 1'b0;
    cyc();
    // zero-stall store, drain held for three cycles
    wr_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h1234;
    @(negedge clk); chkb("s34_stall0", stall_o, 1'b0);
    cyc(); wr_i = 1'b0;
    @(negedge clk); chkb("s34_noreq", mem_req_o, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = (i == 2);
      @(negedge clk);
      chkb("s34_req", mem_req_o, 1'b1);
      chkb("s34_we", mem_we_o, 1'b1);
      chk("s34_addr", mem_addr_o, 32'h10);
      chk("s34_wdata", mem_wdata_o, 32'h1234);
      chkb("s34_stall", stall_o, 1'b0);
      cyc();
    end
    mem_ack_i = 1'b0;
    repeat (2) begin
      @(negedge clk); chkb("s34_drained", mem_req_o, 1'b0);
      cyc();
    end
    // store then forwarded load of the same word
    wr_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hAAAA;
    @(negedge clk); chkb("s35_stall0", stall_o, 1'b0);
    cyc(); wr_i = 1'b0; rd_i = 1'b1; addr_i = 32'h22;
    @(negedge clk);
    chk("s35_rdata", rdata_o, 32'hAAAA);
    chkb("s35_rvalid", rvalid_o, 1'b1);
    chkb("s35_stall", stall_o, 1'b0);
    cyc(); rd_i = 1'b0;
    drain_ack();
    cyc();
    // load miss, memory answers in the fifth stalled cycle
    rd_i = 1'b1; addr_i = 32'h40; mem_rdata_i = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      mem_ack_i = (i == 4);
      @(negedge clk);
      chkb("s36_stall", stall_o, 1'b1);
      chkb("s36_req", mem_req_o, i > 0);
      cyc();
    end
    mem_ack_i = 1'b0;
    @(negedge clk);
    chkb("s36_rvalid", rvalid_o, 1'b1);
    chk("s36_rdata", rdata_o, 32'hCAFEF00D);
    chkb("s36_stall", stall_o, 1'b0);
    cyc(); rd_i = 1'b0;
    cyc();
    // buffered store must drain before a missing load is issued
    wr_i = 1'b1; addr_i = 32'h50; wdata_i = 32'h5;
    @(negedge clk); chkb("s37_stall0", stall_o, 1'b0);
    cyc(); wr_i = 1'b0; rd_i = 1'b1; addr_i = 32'h60; mem_rdata_i = 32'h777;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ack_i = mem_req_o;
      if (mem_req_o) q_we.push_back(mem_we_o);
      @(negedge clk);
      if (rvalid_o) begin
        done = 1'b1;
        chk("s37_rdata", rdata_o, 32'h777);
        chkb("s37_stall_done", stall_o, 1'b0);
        break;
      end
      chkb("s37_stall", stall_o, 1'b1);
      cyc();
    end
    chkb("s37_done", done, 1'b1);
    chk("s37_nops", q_we.size(), 32'd2);
    if (q_we.size() == 2) begin
      chkb("s37_first_write", q_we[0], 1'b1);
      chkb("s37_then_read", q_we[1], 1'b0);
    end
    cyc(); rd_i = 1'b0; mem_ack_i = 1'b0;
    cyc();
    // unanswered load times out after T request cycles
    rd_i = 1'b1; addr_i = 32'h80;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) chkb("s38_req", mem_req_o, i >= 1);
      else begin
        chkb("s38_req_drop", mem_req_o, 1'b0);
        chkb("s38_rvalid", rvalid_o, 1'b1);
        chk("s38_rdata", rdata_o, 32'h0);
        chkb("s38_err", err_o, 1'b1);
        chkb("s38_stall", stall_o, 1'b0);
      end
      cyc();
    end
    rd_i = 1'b0;
    @(negedge clk); chkb("s38_err_sticky", err_o, 1'b1);
    cyc();
    // reset during a read abandons it; a late ack does nothing
    rd_i = 1'b1; addr_i = 32'h90;
    @(negedge clk); chkb("s39_idle", mem_req_o, 1'b0);
    cyc();
    @(negedge clk); chkb("s39_rd", mem_req_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chkb("s39_req_async", mem_req_o, 1'b0);
    chkb("s39_stall_rst", stall_o, 1'b0);
    chkb("s39_err_clr", err_o, 1'b0);
    cyc(); cyc();
    rst_i = 1'b0; rd_i = 1'b0; mem_ack_i = 1'b1;
    cyc(); mem_ack_i = 1'b0;
    @(negedge clk);
    chkb("s39_late_ack_req", mem_req_o, 1'b0);
    chkb("s39_late_ack_rvalid", rvalid_o, 1'b0);
    chkb("s39_late_ack_err", err_o, 1'b0);
    // randomized pipeline traffic against a random-latency memory
    st_prev = 1'b0; lat_cnt = 0; lat_tgt = 2;
    for (int n = 0; n < 4000; n++) begin
      cyc();
      if (rst_i) rst_i = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst_i = 1'b1;
      if (!st_prev) begin
        r = int'($urandom_range(0, 31));
        rd_i = (r >= 8 && r <= 17) || r == 31;
        wr_i = (r >= 18 && r <= 27) || r == 31;
        addr_i = 32'h100 + $urandom_range(0, 15);
        wdata_i = $urandom;
      end
      if (mem_req_o) begin
        lat_cnt++;
        mem_ack_i = lat_cnt >= lat_tgt;
        if (mem_ack_i) begin
          lat_cnt = 0;
          lat_tgt = int'($urandom_range(1, 6));
        end
      end else begin
        lat_cnt = 0;
        lat_tgt = int'($urandom_range(1, 6));
        mem_ack_i = $urandom_range(0, 15) == 0;
      end
      mem_rdata_i = $urandom;
      @(negedge clk);
      st_prev = stall_o;
    end
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
